// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared widths, state encoding and lane-slice helper for stream_demux
package stream_demux_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_N_OUT = 4;
    localparam int DEF_CNT_W = 16;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    function automatic int lane_lo(int k, int w);
        return k * w;
    endfunction
endpackage

// File: rtl/stream_demux_stage.sv
// stream_demux_stage: single-entry holding register with full flag and ready logic
module stream_demux_stage
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W = 2
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_valid,
    input  logic              load_ok,
    input  logic              drain,
    output logic              in_ready,
    output logic              full,
    output logic [DATA_W-1:0] data_q,
    output logic [SEL_W-1:0]  sel_q
);
    state_t state, state_n;
    logic load;
    assign full = state == FULL;
    assign in_ready = !full || drain;
    assign load = in_valid && in_ready && load_ok;
    always_comb begin
        state_n = (load || (full && !drain)) ? FULL : EMPTY;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            data_q <= '0;
            sel_q <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                data_q <= in_data;
                sel_q <= in_sel;
            end
        end
    end
endmodule

// File: rtl/stream_demux.sv
// stream_demux: 1-to-N registered valid/ready demux; DEMUX_STATS_EN adds per-channel drain counters
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_OUT = DEF_N_OUT,
`ifdef DEMUX_STATS_EN
    parameter int CNT_W = DEF_CNT_W,
`endif
    localparam int SEL_W = $clog2(N_OUT)
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic                    sel_err,
    input  logic                    err_clr
`ifdef DEMUX_STATS_EN
    ,
    output logic [N_OUT*CNT_W-1:0]  stat_cnt
`endif
);
    logic full, drain, in_range;
    logic [DATA_W-1:0] data_q;
    logic [SEL_W-1:0] sel_q;
    assign in_range = 32'(in_sel) < N_OUT;
    assign drain = |(out_valid & out_ready);
    stream_demux_stage #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_stage (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .load_ok(in_range), .drain(drain),
        .in_ready(in_ready), .full(full), .data_q(data_q), .sel_q(sel_q)
    );
    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        assign out_valid[k] = full && sel_q == SEL_W'(k);
        assign out_data[lane_lo(k, DATA_W) +: DATA_W] = out_valid[k] ? data_q : '0;
`ifdef DEMUX_STATS_EN
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt <= '0;
            else if (out_valid[k] && out_ready[k]) cnt <= cnt + CNT_W'(1);
        end
        assign stat_cnt[lane_lo(k, CNT_W) +: CNT_W] = cnt;
`endif
    end
    // a bad accept in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_err <= 1'b0;
        else if (in_valid && in_ready && !in_range) sel_err <= 1'b1;
        else if (err_clr) sel_err <= 1'b0;
    end
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed self-checking bench for stream_demux (N_OUT=4 and N_OUT=5 instances)
module tb_stream_demux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] a_data = '0;
    logic [1:0] a_sel = '0;
    logic a_valid = 1'b0, a_ready_in, a_err, a_clr = 1'b0;
    logic [31:0] a_out;
    logic [3:0] a_ov, a_or = 4'b1111;

    logic [7:0] b_data = '0;
    logic [2:0] b_sel = '0;
    logic b_valid = 1'b0, b_ready_in, b_err, b_clr = 1'b0;
    logic [39:0] b_out;
    logic [4:0] b_ov, b_or = 5'b11111;

    int checks = 0;
    int failures = 0;

`ifdef DEMUX_STATS_EN
    logic [15:0] a_stat;
    stream_demux #(.CNT_W(4)) dut_a (
`else
    stream_demux dut_a (
`endif
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel), .in_valid(a_valid),
        .in_ready(a_ready_in), .out_data(a_out), .out_valid(a_ov), .out_ready(a_or),
        .sel_err(a_err), .err_clr(a_clr)
`ifdef DEMUX_STATS_EN
        , .stat_cnt(a_stat)
`endif
    );

`ifdef DEMUX_STATS_EN
    logic [79:0] b_stat;
`endif
    stream_demux #(.N_OUT(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel), .in_valid(b_valid),
        .in_ready(b_ready_in), .out_data(b_out), .out_valid(b_ov), .out_ready(b_or),
        .sel_err(b_err), .err_clr(b_clr)
`ifdef DEMUX_STATS_EN
        , .stat_cnt(b_stat)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_d;
        #1;
        chk("rst_ov", 64'(a_ov), 64'h0);
        chk("rst_od", 64'(a_out), 64'h0);
        chk("rst_rdy", 64'(a_ready_in), 64'h1);
        chk("rst_err", 64'(a_err), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        a_data = 8'hA5; a_sel = 2'd2; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("single_ov", 64'(a_ov), 64'h4);
        chk("single_od", 64'(a_out), 64'h00A50000);
        tick();
        chk("single_done", 64'(a_ov), 64'h0);

        a_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_data = 8'h10 + 8'(i);
            a_sel = 2'(i);
            #1;
            chk("sus_rdy", 64'(a_ready_in), 64'h1);
            tick();
            exp_d = 32'(8'h10 + 8'(i)) << (8 * (i % 4));
            chk("sus_ov", 64'(a_ov), 64'(4'b0001 << (i % 4)));
            chk("sus_od", 64'(a_out), 64'(exp_d));
        end
        a_valid = 1'b0;
        tick();

        a_or = 4'b1101;
        a_data = 8'h3C; a_sel = 2'd1; a_valid = 1'b1;
        tick();
        a_data = 8'h77; a_sel = 2'd3;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rdy", 64'(a_ready_in), 64'h0);
            chk("bp_od", 64'(a_out), 64'h00003C00);
            chk("bp_ov", 64'(a_ov), 64'h2);
            tick();
        end
        a_or = 4'b1111;
        #1;
        chk("bp_release_rdy", 64'(a_ready_in), 64'h1);
        tick();
        a_valid = 1'b0;
        chk("bp_next_ov", 64'(a_ov), 64'h8);
        chk("bp_next_od", 64'(a_out), 64'h77000000);
        tick();
        chk("bp_empty", 64'(a_ov), 64'h0);

        b_data = 8'h44; b_sel = 3'd4; b_valid = 1'b1;
        tick();
        chk("b_good_ov", 64'(b_ov), 64'h10);
        chk("b_good_od", 64'(b_out), 64'h44_00000000);
        b_sel = 3'd6; b_data = 8'h99;
        #1;
        chk("b_bad_rdy", 64'(b_ready_in), 64'h1);
        tick();
        b_valid = 1'b0;
        chk("b_bad_ov", 64'(b_ov), 64'h0);
        chk("b_bad_od", 64'(b_out), 64'h0);
        chk("b_err_set", 64'(b_err), 64'h1);
        b_clr = 1'b1; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        chk("b_err_win", 64'(b_err), 64'h1);
        chk("b_bad2_ov", 64'(b_ov), 64'h0);
        tick();
        b_clr = 1'b0;
        chk("b_err_clr", 64'(b_err), 64'h0);

        a_or = 4'b0000;
        a_data = 8'h5A; a_sel = 2'd0; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("mid_held", 64'(a_ov), 64'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", 64'(a_ov), 64'h0);
        chk("mid_rst_od", 64'(a_out), 64'h0);
        chk("mid_rst_rdy", 64'(a_ready_in), 64'h1);
        tick();
        rst_n = 1'b1;
        a_or = 4'b1111;
        tick();
        chk("post_rst_ov", 64'(a_ov), 64'h0);
        chk("post_rst_rdy", 64'(a_ready_in), 64'h1);

`ifdef DEMUX_STATS_EN
        chk("stat_rst", 64'(a_stat), 64'h0);
        a_sel = 2'd3; a_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            a_data = 8'(i);
            tick();
        end
        a_valid = 1'b0;
        tick();
        chk("stat_wrap", 64'(a_stat), 64'h1000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
Parametrised 1-to-N demultiplexer with valid/ready handshake and one registered pipeline stage.
- Routes each input beat to the output channel chosen by a select value sampled with the data.
- Unselected lanes hold zero.
- Successor of the 4-way combinational demux; sits between a single producer and N independent consumers (per-channel FIFOs, display or UART sinks).

Parameters:
- DATA_W, 8: width of one data beat.
- N_OUT, 4: number of output channels, 2..16.
- SEL_W, $clog2(N_OUT): select width; derived, not overridden.
- CNT_W, 16: width of each per-channel beat counter (used only with the optional feature).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_data  input  DATA_W  input beat.
- in_sel  input  SEL_W  destination channel for the beat.
- in_valid  input  1  beat present.
- in_ready  output  1  block can accept a beat this cycle.
- out_data  output  N_OUT*DATA_W  lane k at bits [k*DATA_W +: DATA_W].
- out_valid  output  N_OUT  per-channel valid; at most one bit set.
- out_ready  input  N_OUT  per-channel ready.
- sel_err  output  1  sticky: an out-of-range select was seen.
- err_clr  input  1  synchronous clear of sel_err.
- stat_cnt  output  N_OUT*CNT_W  per-channel counters; present only with DEMUX_STATS_EN.

Behaviour:
- Reset (rst_n low, asynchronous): holding register empty, sel_q=0, data_q=0, out_valid=0, out_data=0, sel_err=0, counters=0. Reset mid-transfer discards the held beat; no output fires.
- Accept: beat accepted when in_valid & in_ready.
- Drain: held beat drains when out_valid[sel_q] & out_ready[sel_q].
- in_ready = !full | drain. Combinational from out_ready. Accept and drain may occur in the same cycle, giving one beat per cycle sustained.
- Latency: an accepted beat appears on out_valid/out_data the cycle after acceptance.
- Stability: while out_valid[k] is high and out_ready[k] is low, lane k data and sel_q hold stable.
- Lanes: out_data lane sel_q = data_q when full. All other lanes, and all lanes when empty, are 0.
- Out-of-range select (in_sel >= N_OUT, possible only when N_OUT is not a power of two):
  - The beat is accepted normally (handshake completes) but not loaded.
  - full becomes 0 unless it stays 1 with no drain.
  - sel_err is set the next cycle.
  - A simultaneous drain of the previously held beat still completes.
- State: full/empty flag only (two states: EMPTY, FULL).
  - EMPTY→FULL on a valid accept.
  - FULL→EMPTY on a drain with no valid accept.
  - FULL→FULL on drain plus accept, or on no drain.
- sel_err: set on an out-of-range accept; cleared by err_clr. Set wins if both occur in the same cycle.
- Backpressure isolation: a stall on one channel blocks all channels, with no reordering.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined: stat_cnt port present. Counter k increments by 1 on each drain of channel k and wraps from 2^CNT_W-1 to 0. Counters are reset by rst_n only; err_clr does not affect them. Out-of-range beats are not counted.
- Undefined: port and counters absent. All other behaviour is identical.

Decomposition:
- Shared header/package holds:
  - the lane-slice helper (`k*DATA_W` offset macro),
  - the default widths,
  - the EMPTY/FULL state encoding constants.
- Natural sub-module: stream_demux_stage, the single-entry holding register with full flag and ready logic.
- Top level adds select decode, lane zeroing, error flag and optional counters.

Test Plan:
- Reset/idle: assert rst_n=0 mid-stream with a beat held → out_valid=0, out_data=0, in_ready=1 immediately and after release.
- Single beat: send in_data=8'hA5, in_sel=2, out_ready=4'b1111 → next cycle out_valid=4'b0100, lane 2=8'hA5, lanes 0,1,3=0.
- Sustained throughput: 8 back-to-back beats, sel cycling 0..3, all ready → one output per cycle, in order, in_ready constantly 1.
- Backpressure: hold out_ready[1]=0 with 8'h3C held for channel 1 → in_ready=0, lane 1 stable for 5 cycles; raising out_ready[1] drains the beat and accepts the next beat in the same cycle.
- Out-of-range select (N_OUT=5 override): in_sel=6 → handshake completes, no out_valid, sel_err=1 next cycle; err_clr and a second bad select in the same cycle → sel_err stays 1.
- Stats (DEMUX_STATS_EN, CNT_W=4): 17 drains on channel 3 → stat_cnt lane 3 = 1 (wrapped), other lanes 0.
